// File: rtl/rr_pkt_arbiter.sv
// Packet-aware round-robin arbiter: one output port shared by N requesters.
// Latency: grant registered one edge after req is seen in IDLE; release takes one edge.
// Backpressure: rdy stalls beats and holds the grant; a stall watchdog and req-drop abort free the port.
module rr_pkt_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16,
  parameter int LENW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 vld,
  input  logic                 last,
  input  logic                 rdy,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic [LENW-1:0]      pkt_len,
  output logic                 timeout_err,
  output logic                 abort
);

  localparam int IDW = $clog2(N);
  // Stall counter only needs to reach TIMEOUT-1 before the watchdog fires.
  localparam int SW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state_q,   state_d;
  logic [N-1:0]    gnt_q,     gnt_d;
  logic [IDW-1:0]  gnt_id_q,  gnt_id_d;
  logic [IDW-1:0]  ptr_q,     ptr_d;
  logic [LENW-1:0] beat_q,    beat_d;
  logic [SW-1:0]   stall_q,   stall_d;
  logic [LENW-1:0] pkt_len_q, pkt_len_d;
  logic            tmo_q,     tmo_d;
  logic            abort_q,   abort_d;

  logic            pick_vld;
  logic [IDW-1:0]  pick_id;
  logic            xfer;
  logic            rel_done, rel_abort, rel_tmo;
  logic [LENW-1:0] beat_inc;

  // Round-robin pick: walk from ptr downward so the lowest offset from ptr wins.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(idx);
      end
    end
  end

  // Release conditions, evaluated in priority order: completion, abort, watchdog.
  always_comb begin
    xfer      = vld & rdy & (state_q == GRANT);
    beat_inc  = (&beat_q) ? beat_q : beat_q + 1'b1;
    rel_done  = xfer & last;
    rel_abort = ~req[gnt_id_q] & ~rel_done;
    rel_tmo   = (TIMEOUT != 0) && (stall_q == SW'(TIMEOUT - 1)) && !xfer
                && !rel_done && !rel_abort;
  end

  // Next-state logic for the IDLE/GRANT controller and its counters.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    stall_d   = stall_q;
    pkt_len_d = pkt_len_q;
    tmo_d     = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d    = N'(1) << pick_id;
          gnt_id_d = pick_id;
          state_d  = GRANT;
        end
      end
      default: begin
        if (rel_done || rel_abort || rel_tmo) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
          beat_d  = '0;
          stall_d = '0;
          abort_d = rel_abort;
          tmo_d   = rel_tmo;
          if (rel_done) pkt_len_d = beat_inc;
        end else begin
          beat_d  = xfer ? beat_inc : beat_q;
          stall_d = xfer ? '0 : stall_q + 1'b1;
        end
      end
    endcase
  end

  // State registers with synchronous reset; reset mid-packet drops the grant silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      beat_q    <= '0;
      stall_q   <= '0;
      pkt_len_q <= '0;
      tmo_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      beat_q    <= beat_d;
      stall_q   <= stall_d;
      pkt_len_q <= pkt_len_d;
      tmo_q     <= tmo_d;
      abort_q   <= abort_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign busy        = (state_q == GRANT);
  assign pkt_len     = pkt_len_q;
  assign timeout_err = tmo_q;
  assign abort       = abort_q;

endmodule

// File: doc/rr_pkt_arbiter.md
# rr_pkt_arbiter

Packet-aware round-robin arbiter that shares one switch output port among N input requesters. A grant is held for a whole packet, until the end-of-packet beat is accepted, rather than being re-arbitrated every cycle. A stall watchdog and a request-drop abort keep a misbehaving requester from locking the port. It sits between the per-input request lines and the output-port mux/FIFO of the switch datapath.

## Interface
Parameters:
- N, 4, number of requesters (2..16).
- TIMEOUT, 16, stall cycles allowed in a grant before forced release; 0 disables the watchdog.
- LENW, 16, width of the packet-length counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  per-requester request; bit i stays high from packet start until its last beat is accepted.
- vld  in  1  beat valid from the currently granted source (after the mux).
- last  in  1  qualifies vld; marks the final beat of the packet.
- rdy  in  1  downstream (output FIFO) ready.
- gnt  out  N  one-hot grant, registered; all zero when idle.
- gnt_id  out  clog2(N)  index of the granted requester; holds its last value when idle.
- busy  out  1  high while in GRANT.
- pkt_len  out  LENW  beat count of the most recently completed packet, saturating.
- timeout_err  out  1  one-cycle pulse on watchdog release.
- abort  out  1  one-cycle pulse when the granted req drops before last.

## Operation
- Reset values: gnt=0, gnt_id=0, busy=0, pkt_len=0, timeout_err=0, abort=0, state=IDLE, priority pointer ptr=0, stall counter=0, beat counter=0.
- A transfer (xfer) is a cycle with vld & rdy & busy.
- State IDLE:
  - If req≠0, pick the first set bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Register the pick into gnt/gnt_id and go to GRANT.
  - If req=0, stay in IDLE.
- State GRANT:
  - Beat counter: increments on each xfer, saturating at 2^LENW-1.
  - Stall counter: cleared on xfer, otherwise increments.
  - Release on the first of these, in priority order:
    - (a) xfer & last: normal completion. pkt_len ← beat count including this beat.
    - (b) req[gnt_id]=0 without xfer&last: abort pulses. pkt_len is unchanged.
    - (c) TIMEOUT≠0 & stall count = TIMEOUT-1 & no xfer: timeout_err pulses. pkt_len is unchanged.
  - On any release:
    - gnt ← 0, busy ← 0, state ← IDLE.
    - ptr ← (gnt_id+1) mod N.
    - Beat and stall counters ← 0.
- Fairness: ptr advances only on release, so every requester with req held is granted within N packets (or N watchdog releases).
- Requests that rise while a grant is active are not seen until the next IDLE cycle.
- vld/last/rdy are ignored in IDLE.
- rst in any state, including mid-packet, returns every register to its reset value on that edge. No pulse is generated.

## Timing
- Grant latency: req seen in IDLE at edge t → gnt/busy high after edge t (visible in cycle t+1).
- Release latency: release condition in cycle t → gnt=0 and state IDLE in cycle t+1.
  - Earliest next grant is cycle t+2, so there is one dead cycle between packets.
- pkt_len, timeout_err and abort update together with the gnt drop, in cycle t+1.
  - The pulses are exactly one cycle wide.
- Watchdog: with no xfer, the forced release is visible exactly TIMEOUT cycles after the grant cycle or the last xfer.
- A single-beat packet (xfer&last in the first GRANT cycle) gives busy high for one cycle and pkt_len=1.
- Simultaneous events:
  - xfer&last while req drops in the same cycle → completion, no abort.
  - xfer while the stall count is at TIMEOUT-1 → no timeout.

## Test plan
- Reset behaviour: assert rst with req=4'b1111 → gnt=0, busy=0, and ptr=0 on deassert. The first grant is gnt=4'b0001.
- Round-robin rotation: req=4'b1111 constant, 3-beat packets with rdy=1 → grant order 0,1,2,3,0. pkt_len=3 after each packet, one dead cycle between grants.
- Grant hold: grant to 1 while req=4'b0011 and rdy toggling → gnt stays 4'b0010 until the last beat is accepted; pkt_len equals the accepted beat count.
- Watchdog: TIMEOUT=16, grant 2, vld=0 → timeout_err pulses and gnt=0 in cycle 17 after the grant. The next grant goes to 3 if 3 is requesting, else 0.
- Abort: drop req[0] after 2 beats → abort pulses, pkt_len unchanged, ptr=1.
- Boundaries:
  - Single-beat packet → pkt_len=1.
  - Reset mid-packet → all outputs return to reset values on the next edge.
  - Ptr wrap 3→0 → checked.
